vproc_bus_responder: RTL and testbench

- Slave-side responder that sits directly downstream of the VProc virtual processor bus.
- Consumes the processor's Addr/BE/WE/RD/DataOut/Burst signals and produces DataIn, WRAck and RDAck with programmable wait states.
- Contains a word-addressed memory, an interrupt control register that drives the processor's Interrupt input, and the UpdateResponse echo needed for delta-cycle handshaking.
- Used as the default memory/peripheral model in VProc test harnesses.

---
 rtl/vproc_bus_responder.sv | 131 +++++++++++++
 tb/tb_vproc_bus_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_bus_responder.sv
// Slave responder for the VProc virtual processor bus: word memory, interrupt
// control register and programmable wait-state acknowledge timing.
module vproc_bus_responder #(
  parameter int          MEM_ADDR_WIDTH    = 10,
  parameter int          INT_WIDTH         = 3,
  parameter int          WAIT_STATES       = 1,
  parameter int          BURST_WAIT_STATES = 0,
  parameter logic [31:0] IRQ_ADDR          = 32'hFFFF_FFF0
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic [31:0]          Addr,
  input  logic [3:0]           BE,
  input  logic                 WE,
  input  logic                 RD,
  input  logic [31:0]          DataOut,
  input  logic [11:0]          Burst,
  input  logic                 BurstFirst,
  input  logic                 BurstLast,
  input  logic                 Update,
  output logic [31:0]          DataIn,
  output logic                 WRAck,
  output logic                 RDAck,
  output logic                 UpdateResponse,
  output logic [INT_WIDTH-1:0] Interrupt,
  output logic [15:0]          ErrCount
);

  localparam int         MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  logic [1:0]                state_reg;
  logic [15:0]               cnt_reg;
  logic [31:0]               addr_reg;
  logic [31:0]               data_reg;
  logic [3:0]                be_reg;
  logic                      we_reg;
  logic                      rd_reg;
  logic [31:0]               mem [MEM_DEPTH];

  logic [MEM_ADDR_WIDTH-1:0] mem_idx;
  logic                      is_irq;
  logic                      out_of_range;
  logic                      do_access;
  logic                      mem_we;
  logic                      access_err;
  logic [15:0]               wait_load;
  logic                      unused_burst_last;

  assign UpdateResponse    = Update;
  assign unused_burst_last = BurstLast;

  assign mem_idx      = addr_reg[MEM_ADDR_WIDTH-1:0];
  assign is_irq       = (addr_reg == IRQ_ADDR);
  assign out_of_range = !is_irq && ((addr_reg >> MEM_ADDR_WIDTH) != 32'd0);
  // The access completes on the edge that leaves WAIT with the count exhausted,
  // which places the ack W+1 edges after capture.
  assign do_access    = (state_reg == ST_WAIT) && (cnt_reg == 16'd0);
  assign mem_we       = do_access && we_reg && !is_irq && !out_of_range;
  assign access_err   = out_of_range || (we_reg && rd_reg);
  assign wait_load    = ((Burst != 12'd0) && !BurstFirst) ? 16'(BURST_WAIT_STATES)
                                                          : 16'(WAIT_STATES);

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_reg[i]) mem[mem_idx][8*i +: 8] <= data_reg[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 16'd0;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      be_reg    <= 4'd0;
      we_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      DataIn    <= 32'd0;
      WRAck     <= 1'b0;
      RDAck     <= 1'b0;
      Interrupt <= '0;
      ErrCount  <= 16'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          WRAck <= 1'b0;
          RDAck <= 1'b0;
          if (RD || WE) begin
            addr_reg  <= Addr;
            data_reg  <= DataOut;
            be_reg    <= BE;
            we_reg    <= WE;
            rd_reg    <= RD;
            cnt_reg   <= wait_load;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 16'd0) begin
            state_reg <= ST_ACK;
            if (we_reg) begin
              WRAck <= 1'b1;
              if (is_irq && be_reg[0]) Interrupt <= data_reg[INT_WIDTH-1:0];
            end else begin
              RDAck <= 1'b1;
              if (is_irq)            DataIn <= {{(32-INT_WIDTH){1'b0}}, Interrupt};
              else if (out_of_range) DataIn <= 32'hDEAD_BEEF;
              else                   DataIn <= mem[mem_idx];
            end
            if (access_err && (ErrCount != 16'hFFFF)) ErrCount <= ErrCount + 16'd1;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        ST_ACK: begin
          // The request still visible here is the one being retired.
          WRAck     <= 1'b0;
          RDAck     <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vproc_bus_responder.sv
// Self-checking bench for vproc_bus_responder: directed scenarios plus a
// randomized access stream compared against a behavioural bus/memory model.
module tb_vproc_bus_responder;

  localparam logic [31:0] IRQ = 32'hFFFF_FFF0;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic [3:0]  BE = 4'd0;
  logic        WE = 1'b0;
  logic        RD = 1'b0;
  logic [31:0] DataOut = 32'd0;
  logic [11:0] Burst = 12'd0;
  logic        BurstFirst = 1'b0;
  logic        BurstLast = 1'b0;
  logic        Update = 1'b0;
  logic        sel = 1'b0;

  logic        we_a, rd_a, we_b, rd_b;
  logic [31:0] a_DataIn, b_DataIn;
  logic        a_WRAck, a_RDAck, b_WRAck, b_RDAck;
  logic        a_UpdResp, b_UpdResp;
  logic [2:0]  a_Interrupt, b_Interrupt;
  logic [15:0] a_ErrCount, b_ErrCount;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model of instance A
  logic [31:0] ref_mem [1024];
  logic [2:0]  ref_irq;
  logic [15:0] ref_err;

  assign we_a = WE & ~sel;
  assign rd_a = RD & ~sel;
  assign we_b = WE & sel;
  assign rd_b = RD & sel;

  always #5 Clk = ~Clk;

  vproc_bus_responder #(.WAIT_STATES(1), .BURST_WAIT_STATES(0)) dut_a (
    .Clk(Clk), .nReset(nReset), .Addr(Addr), .BE(BE), .WE(we_a), .RD(rd_a),
    .DataOut(DataOut), .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
    .Update(Update), .DataIn(a_DataIn), .WRAck(a_WRAck), .RDAck(a_RDAck),
    .UpdateResponse(a_UpdResp), .Interrupt(a_Interrupt), .ErrCount(a_ErrCount)
  );

  vproc_bus_responder #(.WAIT_STATES(2), .BURST_WAIT_STATES(0)) dut_b (
    .Clk(Clk), .nReset(nReset), .Addr(Addr), .BE(BE), .WE(we_b), .RD(rd_b),
    .DataOut(DataOut), .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
    .Update(Update), .DataIn(b_DataIn), .WRAck(b_WRAck), .RDAck(b_RDAck),
    .UpdateResponse(b_UpdResp), .Interrupt(b_Interrupt), .ErrCount(b_ErrCount)
  );

  function automatic logic [31:0] ref_access(input bit w, input bit r, input logic [31:0] a,
                                             input logic [3:0] be, input logic [31:0] d);
    logic [31:0] res = 32'd0;
    bit err = w && r;
    if (a == IRQ) begin
      if (w) begin
        if (be[0]) ref_irq = d[2:0];
      end else begin
        res = {29'd0, ref_irq};
      end
    end else if (a >= 32'd1024) begin
      err = 1'b1;
      if (!w) res = 32'hDEAD_BEEF;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a[9:0]][8*i +: 8] = d[8*i +: 8];
    end else begin
      res = ref_mem[a[9:0]];
    end
    if (err && ref_err != 16'hFFFF) ref_err = ref_err + 16'd1;
    return res;
  endfunction

  // Processor-side driver; called at #1 after an edge. Capture is the first
  // following edge; lat counts edges from capture to the ack rising.
  task automatic bus_access(input bit s, input bit w, input bit r, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d, input logic [11:0] burst,
                            input bit first, input bit last,
                            output logic [31:0] rdata, output int lat, output bit seen,
                            output bit other_seen, output bit ack_after);
    logic ack, other;
    sel = s; Addr = a; BE = be; DataOut = d; Burst = burst;
    BurstFirst = first; BurstLast = last; WE = w; RD = r;
    seen = 0; other_seen = 0; lat = 0; rdata = 32'd0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge Clk); #1;
      ack   = s ? (w ? b_WRAck : b_RDAck) : (w ? a_WRAck : a_RDAck);
      other = s ? (w ? b_RDAck : b_WRAck) : (w ? a_RDAck : a_WRAck);
      if (other) other_seen = 1;
      if (ack) begin
        seen = 1; lat = n - 1;
        rdata = s ? b_DataIn : a_DataIn;
      end
    end
    @(posedge Clk); #1;
    WE = 0; RD = 0;
    ack_after = s ? (b_WRAck | b_RDAck) : (a_WRAck | a_RDAck);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (a_DataIn !== 32'd0 || a_WRAck !== 1'b0 || a_RDAck !== 1'b0 ||
        a_Interrupt !== 3'd0 || a_ErrCount !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: DataIn=%h WRAck=%b RDAck=%b Int=%b Err=%0d, want all 0",
               a_DataIn, a_WRAck, a_RDAck, a_Interrupt, a_ErrCount);
    end
    @(negedge Clk); nReset = 1;
    ref_irq = 3'd0; ref_err = 16'd0;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if (a_WRAck !== 1'b0 || a_RDAck !== 1'b0 || b_WRAck !== 1'b0 || b_RDAck !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_ack: acks a=%b%b b=%b%b want 00", a_WRAck, a_RDAck, b_WRAck, b_RDAck);
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    logic [31:0] rd; int lat; bit seen, oth, aft, dummy;
    bus_access(0, 1, 0, 32'd5, 4'hF, 32'h1234_5678, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 0, 32'd5, 4'hF, 32'h1234_5678) != 0);
    n_cmp++;
    if (!seen || lat !== 2 || oth || aft) begin
      n_fail++;
      $display("FAIL single_write: seen=%b lat=%0d other=%b after=%b, want 1/2/0/0", seen, lat, oth, aft);
    end
    bus_access(0, 0, 1, 32'd5, 4'h0, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    n_cmp++;
    if (!seen || lat !== 2 || oth || aft || rd !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL single_read: seen=%b lat=%0d other=%b after=%b data=%h, want 1/2/0/0/12345678",
               seen, lat, oth, aft, rd);
    end
    $display("single: write/read addr 5 data %h lat %0d", rd, lat);
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; int lat; bit seen, oth, aft, dummy;
    bus_access(0, 1, 0, 32'd7, 4'hF, 32'hAABB_CCDD, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 0, 32'd7, 4'hF, 32'hAABB_CCDD) != 0);
    bus_access(0, 1, 0, 32'd7, 4'b0101, 32'h1122_3344, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 0, 32'd7, 4'b0101, 32'h1122_3344) != 0);
    bus_access(0, 0, 1, 32'd7, 4'h0, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    n_cmp++;
    if (!seen || rd !== 32'hAA22_CC44) begin
      n_fail++;
      $display("FAIL byte_enable: seen=%b data=%h, want AA22CC44", seen, rd);
    end
    $display("byte_enable: addr 7 read %h", rd);
  endtask

  task automatic test_burst();
    logic [31:0] rd; int lat; bit seen, oth, aft;
    for (int i = 0; i < 4; i++)
      bus_access(1, 1, 0, 32'd16 + i, 4'hF, i + 1, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    for (int i = 0; i < 4; i++) begin
      bus_access(1, 0, 1, 32'd16 + i, 4'hF, 32'd0, 12'd4, i == 0, i == 3, rd, lat, seen, oth, aft);
      n_cmp++;
      if (!seen || lat !== (i == 0 ? 3 : 1) || rd !== i + 1 || oth || aft) begin
        n_fail++;
        $display("FAIL burst_beat%0d: seen=%b lat=%0d data=%h, want lat %0d data %0d",
                 i, seen, lat, rd, (i == 0 ? 3 : 1), i + 1);
      end
      $display("burst: beat %0d data %h lat %0d", i, rd, lat);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; int lat; bit seen, oth, aft, dummy;
    bus_access(0, 1, 0, IRQ, 4'hF, 32'h5, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 0, IRQ, 4'hF, 32'h5) != 0);
    n_cmp++;
    if (!seen || a_Interrupt !== 3'b101) begin
      n_fail++;
      $display("FAIL irq_set: seen=%b Interrupt=%b, want 101", seen, a_Interrupt);
    end
    bus_access(0, 0, 1, IRQ, 4'h0, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    n_cmp++;
    if (!seen || rd !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL irq_read: data=%h, want 00000005", rd);
    end
    bus_access(0, 1, 0, IRQ, 4'hE, 32'h2, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    n_cmp++;
    if (a_Interrupt !== 3'b101) begin
      n_fail++;
      $display("FAIL irq_be0_gate: Interrupt=%b, want 101", a_Interrupt);
    end
    bus_access(0, 1, 0, IRQ, 4'hF, 32'h0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 0, IRQ, 4'hF, 32'h0) != 0);
    n_cmp++;
    if (a_Interrupt !== 3'b000) begin
      n_fail++;
      $display("FAIL irq_clear: Interrupt=%b, want 000", a_Interrupt);
    end
    $display("irq: set/read/clear done, Interrupt=%b", a_Interrupt);
  endtask

  task automatic test_errors();
    logic [31:0] rd; int lat; bit seen, oth, aft, dummy;
    bus_access(0, 0, 1, 32'h0001_0000, 4'hF, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(0, 1, 32'h0001_0000, 4'hF, 32'd0) != 0);
    n_cmp++;
    if (!seen || lat !== 2 || rd !== 32'hDEAD_BEEF || a_ErrCount !== 16'd1) begin
      n_fail++;
      $display("FAIL oor_read: seen=%b lat=%0d data=%h err=%0d, want 1/2/DEADBEEF/1",
               seen, lat, rd, a_ErrCount);
    end
    bus_access(0, 1, 1, 32'd3, 4'hF, 32'hCAFE_0003, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 1, 32'd3, 4'hF, 32'hCAFE_0003) != 0);
    n_cmp++;
    if (!seen || oth || a_ErrCount !== 16'd2) begin
      n_fail++;
      $display("FAIL rd_we_both: wrack=%b rdack=%b err=%0d, want 1/0/2", seen, oth, a_ErrCount);
    end
    bus_access(0, 0, 1, 32'd3, 4'h0, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    n_cmp++;
    if (rd !== 32'hCAFE_0003) begin
      n_fail++;
      $display("FAIL rd_we_both_data: data=%h, want CAFE0003", rd);
    end
    $display("errors: ErrCount=%0d", a_ErrCount);
  endtask

  task automatic test_update();
    for (int i = 0; i < 4; i++) begin
      Update = ~Update;
      #1;
      n_cmp++;
      if (a_UpdResp !== Update || b_UpdResp !== Update) begin
        n_fail++;
        $display("FAIL update_echo: resp=%b/%b, want %b", a_UpdResp, b_UpdResp, Update);
      end
    end
    $display("update: 4 toggles echoed");
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; int lat; bit seen, oth, aft, dummy, ack_seen;
    bus_access(0, 1, 0, IRQ, 4'hF, 32'h6, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    bus_access(0, 1, 0, 32'd9, 4'hF, 32'h0BAD_F00D, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    dummy = (ref_access(1, 0, 32'd9, 4'hF, 32'h0BAD_F00D) != 0);
    bus_access(0, 0, 1, 32'd9, 4'h0, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    sel = 0; Addr = 32'd9; BE = 4'hF; DataOut = 32'h1111_2222; Burst = 12'd0; WE = 1;
    @(posedge Clk); #4;
    nReset = 0;
    #1;
    n_cmp++;
    if (a_DataIn !== 32'd0 || a_WRAck !== 1'b0 || a_Interrupt !== 3'd0 || a_ErrCount !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: DataIn=%h WRAck=%b Int=%b Err=%0d, want all 0",
               a_DataIn, a_WRAck, a_Interrupt, a_ErrCount);
    end
    Update = ~Update;
    #1;
    n_cmp++;
    if (a_UpdResp !== Update) begin
      n_fail++;
      $display("FAIL update_in_reset: resp=%b, want %b", a_UpdResp, Update);
    end
    ack_seen = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (a_WRAck) ack_seen = 1;
    end
    WE = 0;
    @(negedge Clk); nReset = 1;
    ref_irq = 3'd0; ref_err = 16'd0;
    repeat (2) begin
      @(posedge Clk); #1;
      if (a_WRAck) ack_seen = 1;
    end
    n_cmp++;
    if (ack_seen) begin
      n_fail++;
      $display("FAIL reset_abort_ack: WRAck pulsed=%b, want 0", ack_seen);
    end
    bus_access(0, 0, 1, 32'd9, 4'h0, 32'd0, 12'd0, 0, 0, rd, lat, seen, oth, aft);
    n_cmp++;
    if (!seen || rd !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL reset_abort_mem: data=%h, want 0BADF00D", rd);
    end
    $display("reset_mid_access: addr 9 reads %h", rd);
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp; logic [3:0] be; logic [11:0] burst;
    int lat, elat, kind; bit seen, oth, aft, w, r, first, dummy;
    for (int i = 32; i < 40; i++) begin
      d = $urandom;
      bus_access(0, 1, 0, i, 4'hF, d, 12'd0, 0, 0, rd, lat, seen, oth, aft);
      dummy = (ref_access(1, 0, i, 4'hF, d) != 0);
    end
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = IRQ;
      else if (kind == 1) a = (32'd32 + $urandom_range(0, 7)) | (32'($urandom_range(1, 255)) << 10);
      else                a = 32'd32 + $urandom_range(0, 7);
      w = 1'($urandom_range(0, 1));
      r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
      be = 4'($urandom);
      d = $urandom;
      burst = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'd4;
      first = 1'($urandom_range(0, 1));
      elat = ((burst != 12'd0) && !first) ? 1 : 2;
      exp = ref_access(w, r, a, be, d);
      bus_access(0, w, r, a, be, d, burst, first, 0, rd, lat, seen, oth, aft);
      n_cmp++;
      if (!seen || oth || aft || lat !== elat || (!w && rd !== exp) ||
          a_ErrCount !== ref_err || a_Interrupt !== ref_irq) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h w=%b r=%b seen=%b oth=%b aft=%b lat=%0d/%0d data=%h/%h err=%0d/%0d int=%b/%b",
                 t, a, w, r, seen, oth, aft, lat, elat, rd, exp, a_ErrCount, ref_err, a_Interrupt, ref_irq);
      end
      $display("random %0d: addr=%h we=%b rd=%b be=%h data=%h lat=%0d", t, a, w, r, be, w ? d : rd, lat);
    end
  endtask

  initial begin
    test_reset();
    @(posedge Clk); #1;
    test_single();
    test_byte_enable();
    test_burst();
    test_irq();
    test_errors();
    test_update();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
